// File: rtl/instr_encoder.sv
// instr_encoder: encodes ADD/ADDI/BNE requests into RV32I words, buffered in a FIFO with byte addresses.
module instr_encoder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_kind,
  input  logic [4:0]                    in_rd,
  input  logic [4:0]                    in_rs1,
  input  logic [4:0]                    in_rs2,
  input  logic [12:0]                   in_imm,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDRESS_WIDTH-1:0]      out_instr,
  output logic [ADDRESS_WIDTH-1:0]      out_addr,
  output logic                          err,
  output logic [$clog2(DEPTH):0]        count
);
  localparam int PW = $clog2(DEPTH);

  logic [ADDRESS_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic err_q, err_d;
  logic [31:0] word;
  logic bad, accept, pop, push;

  always_comb begin
    word = in_kind == 2'd0 ? {7'b0, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011} :
           in_kind == 2'd1 ? {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011} :
           {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001, in_imm[4:1], in_imm[11], 7'b1100011};
    bad = in_kind == 2'd3 || (in_kind == 2'd1 && in_imm[12] != in_imm[11]) || (in_kind == 2'd2 && in_imm[0]);
  end

  assign in_ready  = count_q != (PW+1)'(DEPTH);
  assign out_valid = count_q != '0;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign push      = accept && !bad;

  // Rejected requests still complete the handshake; they only raise err.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = accept && bad;
    if (clr) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      addr_d   = BASE_ADDR;
      err_d    = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = ADDRESS_WIDTH'(word);
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        addr_d   = addr_q + ADDRESS_WIDTH'(4);
      end
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  assign out_instr = mem_q[rd_ptr_q];
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign count     = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a queue-based reference model.
module tb_instr_encoder;
  localparam logic [31:0] HI_BASE = 32'hFFFF_FFF8;

  logic clk = 0, rst = 1, clr = 0, in_valid = 0, out_ready = 0;
  logic [1:0] in_kind = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [12:0] in_imm = 0;
  logic in_ready, out_valid, err, in_ready1, out_valid1, err1;
  logic [31:0] out_instr, out_addr, out_instr1, out_addr1;
  logic [2:0] count, count1;

  int n_vec = 0, n_bad = 0;
  logic [31:0] q[$];
  logic [31:0] m_addr = 0;
  bit m_err = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .count(count)
  );

  instr_encoder #(.BASE_ADDR(HI_BASE)) dut_hi (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid1), .out_ready(out_ready), .out_instr(out_instr1), .out_addr(out_addr1),
    .err(err1), .count(count1)
  );

  function automatic bit legal(input logic [1:0] k, input logic [12:0] imm);
    int s = imm >= 4096 ? int'(imm) - 8192 : int'(imm);
    return k != 3 && !(k == 1 && (s < -2048 || s > 2047)) && !(k == 2 && imm % 2 == 1);
  endfunction

  function automatic logic [31:0] enc(input logic [1:0] k, input logic [4:0] rd, rs1, rs2,
                                       input logic [12:0] imm);
    logic [31:0] r = rd, a = rs1, b = rs2, m = imm;
    if (k == 0) return (b << 20) | (a << 15) | (r << 7) | 32'd51;
    if (k == 1) return ((m % 4096) << 20) | (a << 15) | (r << 7) | 32'd19;
    return (((m >> 12) & 1) << 31) | (((m >> 5) & 63) << 25) | (b << 20) | (a << 15) | (32'd1 << 12) |
           (((m >> 1) & 15) << 8) | (((m >> 11) & 1) << 7) | 32'd99;
  endfunction

  task automatic step();
    bit acc, pp, leg;
    acc = in_valid && q.size() != 4;
    pp  = q.size() != 0 && out_ready;
    leg = legal(in_kind, in_imm);
    @(posedge clk);
    if (rst || clr) begin
      q.delete();
      m_addr = 0;
      m_err = 0;
    end else begin
      if (pp) begin
        void'(q.pop_front());
        m_addr += 4;
      end
      if (acc && leg) q.push_back(enc(in_kind, in_rd, in_rs1, in_rs2, in_imm));
      m_err = acc && !leg;
    end
    @(negedge clk);
  endtask

  task automatic req(input logic [1:0] k, input logic [4:0] rd, rs1, rs2, input logic [12:0] imm);
    in_valid = 1; in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic test_reset();
    rst = 1; step(); rst = 0;
    n_vec += 6;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    if (out_addr !== 32'h0 || out_addr1 !== HI_BASE)
      begin n_bad++; $display("FAIL reset_addr got %h/%h want 0/%h", out_addr, out_addr1, HI_BASE); end
    if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got %h want 0", out_instr); end
  endtask

  task automatic test_add();
    out_ready = 1;
    req(0, 3, 1, 2, 0); step(); in_valid = 0;
    n_vec += 3;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b want 1", out_valid); end
    if (out_instr !== 32'h002081B3) begin n_bad++; $display("FAIL add_instr got %h want 002081b3", out_instr); end
    if (out_addr !== 32'h0) begin n_bad++; $display("FAIL add_addr got %h want 0", out_addr); end
    step();
    n_vec++;
    if (out_addr !== 32'h4 || out_valid !== 1'b0)
      begin n_bad++; $display("FAIL add_next got addr %h valid %b want 4/0", out_addr, out_valid); end
  endtask

  task automatic test_addi();
    req(1, 5, 0, 0, 13'h1FFF); step(); in_valid = 0;
    n_vec++;
    if (out_instr !== 32'hFFF00293 || out_valid !== 1'b1)
      begin n_bad++; $display("FAIL addi_instr got %h/%b want fff00293/1", out_instr, out_valid); end
    step();
    req(1, 5, 0, 0, 13'h0800); step(); in_valid = 0;
    n_vec++;
    if (err !== 1'b1 || count !== 3'd0 || out_valid !== 1'b0)
      begin n_bad++; $display("FAIL addi_reject got err %b count %0d valid %b want 1/0/0", err, count, out_valid); end
    step();
    n_vec++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL addi_err_pulse got %b want 0", err); end
  endtask

  task automatic test_bne();
    req(2, 0, 1, 2, 13'h1FFC); step(); in_valid = 0;
    n_vec++;
    if (out_instr !== 32'hFE209EE3) begin n_bad++; $display("FAIL bne_instr got %h want fe209ee3", out_instr); end
    step();
    req(2, 0, 1, 2, 13'h0003); step(); in_valid = 0;
    n_vec++;
    if (err !== 1'b1 || count !== 3'd0) begin n_bad++; $display("FAIL bne_reject got err %b count %0d want 1/0", err, count); end
    step();
    n_vec++;
    if (err !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bne_err_pulse got err %b valid %b want 0/0", err, out_valid); end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    rst = 1; step(); rst = 0;
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin req(0, 5'(i + 1), 1, 2, 0); step(); end
    req(0, 5, 1, 2, 0); step();
    n_vec++;
    if (count !== 3'd4 || in_ready !== 1'b0)
      begin n_bad++; $display("FAIL b2b_full got count %0d ready %b want 4/0", count, in_ready); end
    out_ready = 1;
    for (int c = 0; c < 20 && k < 5; c++) begin
      bit acc = in_valid && q.size() != 4;
      if (out_valid) begin
        n_vec++;
        if (out_instr !== enc(0, 5'(k + 1), 1, 2, 0) || out_addr !== 32'(4 * k))
          begin n_bad++; $display("FAIL b2b_word%0d got %h@%h want %h@%h", k, out_instr, out_addr, enc(0, 5'(k + 1), 1, 2, 0), 4 * k); end
        k++;
      end
      step();
      if (acc) in_valid = 0;
    end
    n_vec++;
    if (k != 5) begin n_bad++; $display("FAIL b2b_count got %0d words want 5", k); end
  endtask

  task automatic test_wrap();
    logic [31:0] want [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    rst = 1; step(); rst = 0;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin req(0, 5'(i), 0, 0, 0); step(); end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (out_addr1 !== want[i] || out_valid1 !== 1'b1)
        begin n_bad++; $display("FAIL wrap_addr%0d got %h/%b want %h/1", i, out_addr1, out_valid1, want[i]); end
      step();
    end
  endtask

  task automatic test_clear(input bit use_rst);
    out_ready = 1;
    req(0, 7, 1, 1, 0); step();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin req(0, 5'(i), 2, 3, 0); step(); end
    req(0, 9, 9, 9, 0);
    if (use_rst) rst = 1; else clr = 1;
    step();
    rst = 0; clr = 0; in_valid = 0;
    n_vec++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0 || out_addr !== 32'h0 || out_addr1 !== HI_BASE)
      begin n_bad++; $display("FAIL %s_state got count %0d valid %b ready %b err %b addr %h/%h want 0/0/1/0/0/%h",
        use_rst ? "rst" : "clr", count, out_valid, in_ready, err, out_addr, out_addr1, HI_BASE); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = $urandom_range(99) == 0;
      clr = $urandom_range(49) == 0;
      out_ready = $urandom_range(2) != 0;
      req(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 13'($urandom));
      in_valid = $urandom_range(3) != 0;
      if ($urandom_range(1) == 0) in_imm = 13'($urandom_range(2047)) & ~13'd1;
      step();
      n_vec++;
      if (count !== 3'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() != 4) || err !== m_err)
        begin n_bad++; $display("FAIL rand_ctl c%0d got cnt %0d v %b r %b e %b want %0d/%b/%b/%b",
          c, count, out_valid, in_ready, err, q.size(), q.size() != 0, q.size() != 4, m_err); end
      if (q.size() != 0) begin
        n_vec++;
        if (out_instr !== q[0] || out_addr !== m_addr || out_addr1 !== m_addr + HI_BASE)
          begin n_bad++; $display("FAIL rand_head c%0d got %h@%h/%h want %h@%h/%h",
            c, out_instr, out_addr, out_addr1, q[0], m_addr, m_addr + HI_BASE); end
      end
    end
    rst = 0; clr = 0; in_valid = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_addi();
    test_bne();
    test_back_to_back();
    test_wrap();
    test_clear(0);
    test_clear(1);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
